// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: tracks in-flight writers past ID, raises load-use stalls,
// IF/ID flush and registered EX forward selects. Optional counters under HAZARD_STATS_EN.
module hazard_scoreboard #(
   parameter int REG_ADDR_W     = 5,
   parameter int NUM_FWD_STAGES = 2,
   parameter int LOAD_LAT       = 1,
   parameter int ZERO_REG       = 31
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rn,
   input  logic [REG_ADDR_W-1:0] id_rm,
   input  logic                  id_uses_rn,
   input  logic                  id_uses_rm,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_regwrite,
   input  logic                  id_is_load,
   input  logic                  br_flush,
   output logic                  stall,
   output logic                  flush_if_id,
   output logic                  bubble_id_ex,
   output logic [2:0]            fwd_sel_a,
   output logic [2:0]            fwd_sel_b
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]           stall_cnt,
   output logic [31:0]           flush_cnt
`endif
);

   localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

   // Index k-1 holds the instruction k stages past ID (index 0 is in EX).
   logic [NUM_FWD_STAGES-1:0]                 vld_q, vld_d;
   logic [NUM_FWD_STAGES-1:0]                 wr_q, wr_d;
   logic [NUM_FWD_STAGES-1:0]                 ld_q, ld_d;
   logic [NUM_FWD_STAGES-1:0][REG_ADDR_W-1:0] rd_q, rd_d;

   logic [NUM_FWD_STAGES-1:0] match_a, match_b;
   logic                      load_use;
   logic [2:0]                sel_a, sel_b;
   logic [2:0]                fwd_sel_a_q, fwd_sel_a_d;
   logic [2:0]                fwd_sel_b_q, fwd_sel_b_d;

   always_comb begin
      match_a = '0;
      match_b = '0;
      for (int k = 0; k < NUM_FWD_STAGES; k++) begin
         match_a[k] = vld_q[k] & wr_q[k] & (rd_q[k] == id_rn) & (id_rn != ZERO_ADDR) & id_uses_rn;
         match_b[k] = vld_q[k] & wr_q[k] & (rd_q[k] == id_rm) & (id_rm != ZERO_ADDR) & id_uses_rm;
      end
   end

   always_comb begin
      load_use = 1'b0;
      for (int k = 0; k < LOAD_LAT; k++) begin
         load_use = load_use | (ld_q[k] & (match_a[k] | match_b[k]));
      end
   end

   assign stall        = ~reset & id_valid & load_use;
   assign bubble_id_ex = stall;
   assign flush_if_id  = ~reset & br_flush & ~stall;

   // Scan oldest to youngest so the youngest producer overwrites.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
         if (match_a[k]) sel_a = 3'(k + 1);
         if (match_b[k]) sel_b = 3'(k + 1);
      end
      fwd_sel_a_d = stall ? 3'd0 : sel_a;
      fwd_sel_b_d = stall ? 3'd0 : sel_b;
   end

   always_comb begin
      vld_d    = '0;
      wr_d     = '0;
      ld_d     = '0;
      rd_d     = '0;
      vld_d[0] = id_valid & ~stall;
      wr_d[0]  = id_regwrite;
      ld_d[0]  = id_is_load;
      rd_d[0]  = id_rd;
      for (int k = 1; k < NUM_FWD_STAGES; k++) begin
         vld_d[k] = vld_q[k-1];
         wr_d[k]  = wr_q[k-1];
         ld_d[k]  = ld_q[k-1];
         rd_d[k]  = rd_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q       <= '0;
         fwd_sel_a_q <= '0;
         fwd_sel_b_q <= '0;
      end else begin
         vld_q       <= vld_d;
         fwd_sel_a_q <= fwd_sel_a_d;
         fwd_sel_b_q <= fwd_sel_b_d;
      end
   end

   // Payload fields are qualified by vld_q, so they need no reset.
   always_ff @(posedge clk) begin
      wr_q <= wr_d;
      ld_q <= ld_d;
      rd_q <= rd_d;
   end

   assign fwd_sel_a = fwd_sel_a_q;
   assign fwd_sel_b = fwd_sel_b_q;

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF))       stall_cnt_d = stall_cnt_q + 32'd1;
      if (flush_if_id && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized bench: two scoreboard configurations share one random instruction stream and
// are compared against a queue-based model of in-flight instructions.
module tb_hazard_scoreboard;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, id_valid, id_uses_rn, id_uses_rm, id_regwrite, id_is_load, br_flush;
   logic [4:0] id_rn, id_rm, id_rd;

   logic       stall0, flush0, bub0, stall1, flush1, bub1;
   logic [2:0] fa0, fb0, fa1, fb1;
`ifdef HAZARD_STATS_EN
   logic [31:0] sc0, fc0, sc1, fc1;
   longint      m_sc[2], m_fc[2];
`endif

   hazard_scoreboard u_d0 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
      .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_is_load(id_is_load), .br_flush(br_flush),
      .stall(stall0), .flush_if_id(flush0), .bubble_id_ex(bub0),
      .fwd_sel_a(fa0), .fwd_sel_b(fb0)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(sc0), .flush_cnt(fc0)
`endif
   );

   hazard_scoreboard #(.NUM_FWD_STAGES(3), .LOAD_LAT(2)) u_d1 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
      .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_is_load(id_is_load), .br_flush(br_flush),
      .stall(stall1), .flush_if_id(flush1), .bubble_id_ex(bub1),
      .fwd_sel_a(fa1), .fwd_sel_b(fb1)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
   );

   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
   } instr_t;

   // Element 0 is the youngest instruction past ID.
   instr_t hist0[$], hist1[$];
   int     depth[2]   = '{2, 3};
   int     loadlat[2] = '{1, 2};
   int     n_chk = 0;
   int     n_fail = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit produces(input instr_t e, input logic [4:0] op, input logic uses);
      return uses && e.v && e.wr && (e.rd == op) && (op != 5'd31);
   endfunction

   function automatic instr_t entry(input int which, input int idx);
      return (which == 0) ? hist0[idx] : hist1[idx];
   endfunction

   task automatic predict(input int which, output bit exp_stall, output int exp_a, output int exp_b);
      instr_t e;
      exp_stall = 1'b0;
      exp_a = 0;
      exp_b = 0;
      for (int age = 1; age <= depth[which]; age++) begin
         e = entry(which, age - 1);
         if (age <= loadlat[which] && e.ld &&
             (produces(e, id_rn, id_uses_rn) || produces(e, id_rm, id_uses_rm)))
            exp_stall = 1'b1;
         if (exp_a == 0 && produces(e, id_rn, id_uses_rn)) exp_a = age;
         if (exp_b == 0 && produces(e, id_rm, id_uses_rm)) exp_b = age;
      end
      exp_stall = exp_stall && id_valid && !reset;
      if (reset || exp_stall) begin
         exp_a = 0;
         exp_b = 0;
      end
   endtask

   task automatic advance(input int which, input bit stalled);
      instr_t e;
      e.v  = id_valid && !stalled;
      e.rd = id_rd;
      e.wr = id_regwrite;
      e.ld = id_is_load;
      if (reset) e = '0;
      if (which == 0) begin
         if (reset) foreach (hist0[i]) hist0[i] = '0;
         else begin hist0.push_front(e); void'(hist0.pop_back()); end
      end else begin
         if (reset) foreach (hist1[i]) hist1[i] = '0;
         else begin hist1.push_front(e); void'(hist1.pop_back()); end
      end
   endtask

   initial begin
      logic [4:0] regs [4];
      bit         s[2];
      int         ea[2], eb[2];
      bit         ef[2];
      regs[0] = 5'd1; regs[1] = 5'd2; regs[2] = 5'd3; regs[3] = 5'd31;
      for (int i = 0; i < 2; i++) hist0.push_back('0);
      for (int i = 0; i < 3; i++) hist1.push_back('0);
`ifdef HAZARD_STATS_EN
      m_sc = '{0, 0};
      m_fc = '{0, 0};
`endif
      reset = 1'b1; id_valid = 1'b0; id_rn = '0; id_rm = '0; id_rd = '0;
      id_uses_rn = 1'b0; id_uses_rm = 1'b0; id_regwrite = 1'b0; id_is_load = 1'b0;
      br_flush = 1'b0;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         reset       = (cyc < 2) || ($urandom_range(0, 99) < 2);
         id_valid    = $urandom_range(0, 99) < 85;
         id_rn       = regs[$urandom_range(0, 3)];
         id_rm       = regs[$urandom_range(0, 3)];
         id_rd       = regs[$urandom_range(0, 3)];
         id_uses_rn  = $urandom_range(0, 99) < 80;
         id_uses_rm  = $urandom_range(0, 99) < 80;
         id_regwrite = $urandom_range(0, 99) < 75;
         id_is_load  = $urandom_range(0, 99) < 35;
         br_flush    = $urandom_range(0, 99) < 15;
         #1;
         predict(0, s[0], ea[0], eb[0]);
         predict(1, s[1], ea[1], eb[1]);
         ef[0] = br_flush && !s[0] && !reset;
         ef[1] = br_flush && !s[1] && !reset;
         chk("stall_cfg0", int'(stall0), int'(s[0]));
         chk("bubble_cfg0", int'(bub0), int'(s[0]));
         chk("flush_cfg0", int'(flush0), int'(ef[0]));
         chk("stall_cfg1", int'(stall1), int'(s[1]));
         chk("bubble_cfg1", int'(bub1), int'(s[1]));
         chk("flush_cfg1", int'(flush1), int'(ef[1]));
`ifdef HAZARD_STATS_EN
         for (int w = 0; w < 2; w++) begin
            if (reset) begin
               m_sc[w] = 0;
               m_fc[w] = 0;
            end else begin
               if (s[w] && m_sc[w] < 64'hFFFF_FFFF) m_sc[w]++;
               if (ef[w] && m_fc[w] < 64'hFFFF_FFFF) m_fc[w]++;
            end
         end
`endif
         @(posedge clk);
         advance(0, s[0]);
         advance(1, s[1]);
         #1;
         chk("fwd_a_cfg0", int'(fa0), ea[0]);
         chk("fwd_b_cfg0", int'(fb0), eb[0]);
         chk("fwd_a_cfg1", int'(fa1), ea[1]);
         chk("fwd_b_cfg1", int'(fb1), eb[1]);
`ifdef HAZARD_STATS_EN
         chk("stall_cnt_cfg0", int'(sc0), int'(m_sc[0]));
         chk("flush_cnt_cfg0", int'(fc0), int'(m_fc[0]));
         chk("stall_cnt_cfg1", int'(sc1), int'(m_sc[1]));
         chk("flush_cnt_cfg1", int'(fc1), int'(m_fc[1]));
`endif
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
